// File: rtl/vdp_vram_arbiter_if.sv
// VRAM arbiter bus bundle: display-fetch port, CPU data-port sequencer and
// the single VRAM port. The arbiter is the slave; its environment is the master.
interface vdp_vram_arbiter_if #(
    parameter int VRAM_ADDR_WIDTH = 13
);
    logic [VRAM_ADDR_WIDTH-1:0] vdp_dma_addr;
    logic                       vdp_dma_rd_tick;
    logic [7:0]                 vdp_rd_data;

    logic                       cpu_addr_wr;
    logic [VRAM_ADDR_WIDTH-1:0] cpu_addr_in;
    logic                       cpu_addr_rd_ahead;
    logic                       cpu_data_wr;
    logic [7:0]                 cpu_wdata;
    logic                       cpu_data_rd;
    logic [7:0]                 cpu_rdata;
    logic                       cpu_busy;
    logic                       cpu_overrun;

    logic [VRAM_ADDR_WIDTH-1:0] vram_addr;
    logic                       vram_we;
    logic [7:0]                 vram_din;
    logic [7:0]                 vram_dout;

    modport master (
        output vdp_dma_addr, vdp_dma_rd_tick,
        output cpu_addr_wr, cpu_addr_in, cpu_addr_rd_ahead,
        output cpu_data_wr, cpu_wdata, cpu_data_rd,
        output vram_dout,
        input  vdp_rd_data, cpu_rdata, cpu_busy, cpu_overrun,
        input  vram_addr, vram_we, vram_din
    );

    modport slave (
        input  vdp_dma_addr, vdp_dma_rd_tick,
        input  cpu_addr_wr, cpu_addr_in, cpu_addr_rd_ahead,
        input  cpu_data_wr, cpu_wdata, cpu_data_rd,
        input  vram_dout,
        output vdp_rd_data, cpu_rdata, cpu_busy, cpu_overrun,
        output vram_addr, vram_we, vram_din
    );
endinterface

// File: rtl/vdp_vram_arbiter.sv
// Single-port VRAM arbiter: display fetches always win the port, CPU data-port
// accesses slip into free cycles with auto-increment and read-ahead.
module vdp_vram_arbiter #(
    parameter int VRAM_SIZE       = 8192,
    parameter int VRAM_ADDR_WIDTH = $clog2(VRAM_SIZE)
) (
    input  logic                pxclk,
    input  logic                reset,
    vdp_vram_arbiter_if.slave   bus
);
    localparam logic [VRAM_ADDR_WIDTH-1:0] ADDR_MAX = VRAM_ADDR_WIDTH'(VRAM_SIZE - 1);

    logic [VRAM_ADDR_WIDTH-1:0] addr;
    logic [VRAM_ADDR_WIDTH-1:0] addr_next_inc;
    logic [7:0]                 wbuf;
    logic [7:0]                 cpu_rdata_q;
    logic [7:0]                 vdp_rd_data_q;
    logic                       wr_pend;
    logic                       rd_pend;
    logic                       rd_inflight;
    logic                       vdp_inflight;
    logic                       overrun_q;

    logic                       busy;
    logic                       issue_wr;
    logic                       issue_rd;
    logic                       accept_wr;
    logic                       accept_rd;
    logic                       data_op;

    assign busy          = wr_pend | rd_pend | rd_inflight;
    assign issue_wr      = wr_pend & ~bus.vdp_dma_rd_tick;
    assign issue_rd      = rd_pend & ~wr_pend & ~bus.vdp_dma_rd_tick;
    assign data_op       = bus.cpu_data_wr | bus.cpu_data_rd;
    // An address load swallows any same-cycle data op, so it never counts as an overrun.
    assign accept_wr     = bus.cpu_data_wr & ~busy & ~bus.cpu_addr_wr;
    assign accept_rd     = bus.cpu_data_rd & ~bus.cpu_data_wr & ~busy & ~bus.cpu_addr_wr;
    assign addr_next_inc = (addr == ADDR_MAX) ? '0 : addr + VRAM_ADDR_WIDTH'(1);

    always_comb begin
        bus.vram_addr = addr;
        bus.vram_we   = 1'b0;
        bus.vram_din  = wbuf;
        if (bus.vdp_dma_rd_tick) begin
            bus.vram_addr = bus.vdp_dma_addr;
        end else if (wr_pend) begin
            bus.vram_we   = 1'b1;
        end
    end

    always_ff @(posedge pxclk or posedge reset) begin
        if (reset) begin
            vdp_inflight  <= 1'b0;
            vdp_rd_data_q <= '0;
        end else begin
            vdp_inflight <= bus.vdp_dma_rd_tick;
            if (vdp_inflight) begin
                vdp_rd_data_q <= bus.vram_dout;
            end
        end
    end

    always_ff @(posedge pxclk or posedge reset) begin
        if (reset) begin
            addr     <= '0;
            wbuf     <= '0;
            wr_pend  <= 1'b0;
            rd_pend  <= 1'b0;
        end else begin
            if (bus.cpu_addr_wr) begin
                addr <= bus.cpu_addr_in;
            end else if (issue_wr || issue_rd) begin
                addr <= addr_next_inc;
            end

            if (accept_wr) begin
                wbuf <= bus.cpu_wdata;
            end

            if (bus.cpu_addr_wr || issue_wr) begin
                wr_pend <= 1'b0;
            end else if (accept_wr) begin
                wr_pend <= 1'b1;
            end

            if (bus.cpu_addr_wr) begin
                rd_pend <= bus.cpu_addr_rd_ahead;
            end else if (issue_rd) begin
                rd_pend <= 1'b0;
            end else if (accept_rd) begin
                rd_pend <= 1'b1;
            end
        end
    end

    // Read-ahead data arrives one edge after issue; a completed write also refreshes the buffer.
    always_ff @(posedge pxclk or posedge reset) begin
        if (reset) begin
            rd_inflight <= 1'b0;
            cpu_rdata_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            rd_inflight <= issue_rd;
            if (rd_inflight) begin
                cpu_rdata_q <= bus.vram_dout;
            end
            if (issue_wr) begin
                cpu_rdata_q <= wbuf;
            end

            if (bus.cpu_addr_wr) begin
                overrun_q <= 1'b0;
            end else if (data_op && busy) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign bus.vdp_rd_data = vdp_rd_data_q;
    assign bus.cpu_rdata   = cpu_rdata_q;
    assign bus.cpu_busy    = busy;
    assign bus.cpu_overrun = overrun_q;
endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// Directed, table-driven bench for vdp_vram_arbiter with a behavioural
// single-port VRAM (registered read data) attached to the arbiter.
module tb_vdp_vram_arbiter;
    localparam int AW = 13;

    logic pxclk;
    logic reset;
    int   vec_count;
    int   miscompares;

    vdp_vram_arbiter_if #(.VRAM_ADDR_WIDTH(AW)) bus ();

    vdp_vram_arbiter #(.VRAM_SIZE(8192)) dut (
        .pxclk (pxclk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] mem [0:8191];

    // VRAM model; preload is applied while reset is held so one process owns the array.
    always @(posedge pxclk) begin
        if (reset) begin
            mem[13'h1FFF] <= 8'h3C;
            mem[13'h0000] <= 8'h77;
            mem[13'h0002] <= 8'hE7;
            mem[13'h0800] <= 8'h5A;
            mem[13'h0801] <= 8'h4B;
        end else if (bus.vram_we) begin
            mem[bus.vram_addr] <= bus.vram_din;
        end
        bus.vram_dout <= mem[bus.vram_addr];
    end

    initial pxclk = 1'b0;
    always #5 pxclk = ~pxclk;

    typedef struct {
        logic          tick;
        logic [AW-1:0] dma_addr;
        logic          addr_wr;
        logic [AW-1:0] addr_in;
        logic          rd_ahead;
        logic          data_wr;
        logic [7:0]    wdata;
        logic          data_rd;
        logic [AW-1:0] e_addr;
        logic          e_we;
        logic [7:0]    e_din;
        logic          e_busy;
        logic [7:0]    e_rdata;
        logic          e_ovr;
        logic [7:0]    e_vdp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic tick, input logic [AW-1:0] dma_addr,
        input logic addr_wr, input logic [AW-1:0] addr_in, input logic rd_ahead,
        input logic data_wr, input logic [7:0] wdata, input logic data_rd,
        input logic [AW-1:0] e_addr, input logic e_we, input logic [7:0] e_din,
        input logic e_busy, input logic [7:0] e_rdata, input logic e_ovr,
        input logic [7:0] e_vdp);
        vec_t v;
        v.tick = tick;       v.dma_addr = dma_addr;
        v.addr_wr = addr_wr; v.addr_in = addr_in;   v.rd_ahead = rd_ahead;
        v.data_wr = data_wr; v.wdata = wdata;       v.data_rd = data_rd;
        v.e_addr = e_addr;   v.e_we = e_we;         v.e_din = e_din;
        v.e_busy = e_busy;   v.e_rdata = e_rdata;   v.e_ovr = e_ovr;
        v.e_vdp = e_vdp;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        bus.vdp_dma_rd_tick   = v.tick;
        bus.vdp_dma_addr      = v.dma_addr;
        bus.cpu_addr_wr       = v.addr_wr;
        bus.cpu_addr_in       = v.addr_in;
        bus.cpu_addr_rd_ahead = v.rd_ahead;
        bus.cpu_data_wr       = v.data_wr;
        bus.cpu_wdata         = v.wdata;
        bus.cpu_data_rd       = v.data_rd;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic idleInputs();
        vec_t v;
        v = mk(0, '0, 0, '0, 0, 0, 8'h00, 0, '0, 0, 8'h00, 0, 8'h00, 0, 8'h00);
        applyStimulus(v);
    endtask

    initial begin
        vec_count   = 0;
        miscompares = 0;
        reset       = 1'b1;
        idleInputs();

        //    tick dma       aw ain       ra dw wd     dr  e_addr    we din    busy rdata  ovr vdp
        vecs.push_back(mk(0, 13'h0000, 1, 13'h0100, 0, 0, 8'h00, 0, 13'h0000, 0, 8'h00, 0, 8'h00, 0, 8'h00));
        vecs.push_back(mk(0, 13'h0000, 0, 13'h0000, 0, 1, 8'hA5, 0, 13'h0100, 0, 8'h00, 1, 8'h00, 0, 8'h00));
        vecs.push_back(mk(0, 13'h0000, 0, 13'h0000, 0, 0, 8'h00, 0, 13'h0100, 1, 8'hA5, 0, 8'hA5, 0, 8'h00));
        vecs.push_back(mk(0, 13'h0000, 0, 13'h0000, 0, 0, 8'h00, 0, 13'h0101, 0, 8'h00, 0, 8'hA5, 0, 8'h00));
        vecs.push_back(mk(0, 13'h0000, 1, 13'h1FFF, 1, 0, 8'h00, 0, 13'h0101, 0, 8'h00, 1, 8'hA5, 0, 8'h00));
        vecs.push_back(mk(0, 13'h0000, 0, 13'h0000, 0, 0, 8'h00, 0, 13'h1FFF, 0, 8'h00, 1, 8'hA5, 0, 8'h00));
        vecs.push_back(mk(0, 13'h0000, 0, 13'h0000, 0, 0, 8'h00, 0, 13'h0000, 0, 8'h00, 0, 8'h3C, 0, 8'h00));
        vecs.push_back(mk(0, 13'h0000, 0, 13'h0000, 0, 0, 8'h00, 1, 13'h0000, 0, 8'h00, 1, 8'h3C, 0, 8'h00));
        vecs.push_back(mk(0, 13'h0000, 0, 13'h0000, 0, 0, 8'h00, 0, 13'h0000, 0, 8'h00, 1, 8'h3C, 0, 8'h00));
        vecs.push_back(mk(0, 13'h0000, 0, 13'h0000, 0, 0, 8'h00, 0, 13'h0001, 0, 8'h00, 0, 8'h77, 0, 8'h00));
        vecs.push_back(mk(0, 13'h0000, 0, 13'h0000, 0, 1, 8'hC3, 0, 13'h0001, 0, 8'h00, 1, 8'h77, 0, 8'h00));
        vecs.push_back(mk(1, 13'h0800, 0, 13'h0000, 0, 0, 8'h00, 0, 13'h0800, 0, 8'h00, 1, 8'h77, 0, 8'h00));
        vecs.push_back(mk(1, 13'h0800, 0, 13'h0000, 0, 0, 8'h00, 0, 13'h0800, 0, 8'h00, 1, 8'h77, 0, 8'h5A));
        vecs.push_back(mk(0, 13'h0000, 0, 13'h0000, 0, 0, 8'h00, 0, 13'h0001, 1, 8'hC3, 0, 8'hC3, 0, 8'h5A));
        vecs.push_back(mk(0, 13'h0000, 0, 13'h0000, 0, 0, 8'h00, 1, 13'h0002, 0, 8'h00, 1, 8'hC3, 0, 8'h5A));
        vecs.push_back(mk(0, 13'h0000, 0, 13'h0000, 0, 0, 8'h00, 0, 13'h0002, 0, 8'h00, 1, 8'hC3, 0, 8'h5A));
        vecs.push_back(mk(0, 13'h0000, 0, 13'h0000, 0, 0, 8'h00, 0, 13'h0003, 0, 8'h00, 0, 8'hE7, 0, 8'h5A));
        vecs.push_back(mk(0, 13'h0000, 0, 13'h0000, 0, 1, 8'h11, 0, 13'h0003, 0, 8'h00, 1, 8'hE7, 0, 8'h5A));
        vecs.push_back(mk(0, 13'h0000, 0, 13'h0000, 0, 1, 8'h22, 0, 13'h0003, 1, 8'h11, 0, 8'h11, 1, 8'h5A));
        vecs.push_back(mk(0, 13'h0000, 0, 13'h0000, 0, 0, 8'h00, 0, 13'h0004, 0, 8'h00, 0, 8'h11, 1, 8'h5A));
        vecs.push_back(mk(0, 13'h0000, 1, 13'h0180, 0, 0, 8'h00, 0, 13'h0004, 0, 8'h00, 0, 8'h11, 0, 8'h5A));
        vecs.push_back(mk(0, 13'h0000, 0, 13'h0000, 0, 0, 8'h00, 1, 13'h0180, 0, 8'h00, 1, 8'h11, 0, 8'h5A));
        vecs.push_back(mk(1, 13'h0801, 0, 13'h0000, 0, 0, 8'h00, 0, 13'h0801, 0, 8'h00, 1, 8'h11, 0, 8'h5A));
        vecs.push_back(mk(1, 13'h0800, 1, 13'h0200, 0, 0, 8'h00, 0, 13'h0800, 0, 8'h00, 0, 8'h11, 0, 8'h4B));
        vecs.push_back(mk(0, 13'h0000, 0, 13'h0000, 0, 0, 8'h00, 0, 13'h0200, 0, 8'h00, 0, 8'h11, 0, 8'h5A));
        vecs.push_back(mk(0, 13'h0000, 0, 13'h0000, 0, 1, 8'h66, 1, 13'h0200, 0, 8'h00, 1, 8'h11, 0, 8'h5A));
        vecs.push_back(mk(0, 13'h0000, 0, 13'h0000, 0, 0, 8'h00, 0, 13'h0200, 1, 8'h66, 0, 8'h66, 0, 8'h5A));
        vecs.push_back(mk(0, 13'h0000, 1, 13'h0100, 1, 1, 8'h99, 0, 13'h0201, 0, 8'h00, 1, 8'h66, 0, 8'h5A));
        vecs.push_back(mk(0, 13'h0000, 0, 13'h0000, 0, 0, 8'h00, 0, 13'h0100, 0, 8'h00, 1, 8'h66, 0, 8'h5A));
        vecs.push_back(mk(0, 13'h0000, 0, 13'h0000, 0, 0, 8'h00, 0, 13'h0101, 0, 8'h00, 0, 8'hA5, 0, 8'h5A));

        repeat (3) @(posedge pxclk);
        #3 reset = 1'b0;
        @(posedge pxclk);
        #1;

        vec_count++;
        checkOutput("reset.busy",    16'(bus.cpu_busy),    16'h0);
        checkOutput("reset.rdata",   16'(bus.cpu_rdata),   16'h0);
        checkOutput("reset.overrun", 16'(bus.cpu_overrun), 16'h0);
        checkOutput("reset.vdp",     16'(bus.vdp_rd_data), 16'h0);
        checkOutput("reset.we",      16'(bus.vram_we),     16'h0);
        checkOutput("reset.addr",    16'(bus.vram_addr),   16'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            vec_count++;
            #1;
            checkOutput($sformatf("v%0d.vram_addr", i), 16'(bus.vram_addr), 16'(vecs[i].e_addr));
            checkOutput($sformatf("v%0d.vram_we", i),   16'(bus.vram_we),   16'(vecs[i].e_we));
            if (vecs[i].e_we) begin
                checkOutput($sformatf("v%0d.vram_din", i), 16'(bus.vram_din), 16'(vecs[i].e_din));
            end
            @(posedge pxclk);
            #1;
            checkOutput($sformatf("v%0d.busy", i),    16'(bus.cpu_busy),    16'(vecs[i].e_busy));
            checkOutput($sformatf("v%0d.rdata", i),   16'(bus.cpu_rdata),   16'(vecs[i].e_rdata));
            checkOutput($sformatf("v%0d.overrun", i), 16'(bus.cpu_overrun), 16'(vecs[i].e_ovr));
            checkOutput($sformatf("v%0d.vdp", i),     16'(bus.vdp_rd_data), 16'(vecs[i].e_vdp));
        end

        // Reset while a write is pending: the write strobe must drop without a clock.
        idleInputs();
        bus.cpu_data_wr = 1'b1;
        bus.cpu_wdata   = 8'hF0;
        vec_count++;
        @(posedge pxclk);
        #1;
        idleInputs();
        #1;
        checkOutput("rstmid.we_pending", 16'(bus.vram_we), 16'h1);
        reset = 1'b1;
        #1;
        checkOutput("rstmid.we_async",   16'(bus.vram_we),  16'h0);
        checkOutput("rstmid.busy_async", 16'(bus.cpu_busy), 16'h0);
        @(posedge pxclk);
        #3 reset = 1'b0;
        @(posedge pxclk);
        #1;
        checkOutput("rstmid.addr",    16'(bus.vram_addr),   16'h0);
        checkOutput("rstmid.busy",    16'(bus.cpu_busy),    16'h0);
        checkOutput("rstmid.rdata",   16'(bus.cpu_rdata),   16'h0);
        checkOutput("rstmid.overrun", 16'(bus.cpu_overrun), 16'h0);
        checkOutput("rstmid.vdp",     16'(bus.vdp_rd_data), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end
endmodule
